// File: rtl/relu_maxpool_if.sv
// Stream bundle for the ReLU + 2x2 max-pool stage: raster-order samples in,
// pooled windows with coordinates out.
interface relu_maxpool_if #(
   parameter int OH = 26,
   parameter int OW = 26,
   parameter int DW = 19
);
   localparam int RW = (OH / 2 > 1) ? $clog2(OH / 2) : 1;
   localparam int CW = (OW / 2 > 1) ? $clog2(OW / 2) : 1;

   // Producer side has no ready: in_valid marks a beat that is always taken.
   // out_valid is a one-cycle pulse the consumer must accept.
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic [DW-2:0] out_data;
   logic [RW-1:0] out_row;
   logic [CW-1:0] out_col;
   logic          frame_done;

   modport master (
      output in_valid, in_data,
      input  out_valid, out_data, out_row, out_col, frame_done
   );

   modport slave (
      input  in_valid, in_data,
      output out_valid, out_data, out_row, out_col, frame_done
   );
endinterface

// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling; horizontal pair max in
// a register, vertical pair max through a half-width line buffer.
module relu_maxpool #(
   parameter int OH = 26,
   parameter int OW = 26,
   parameter int DW = 19
) (
   input  logic         clk,
   input  logic         rst,
   relu_maxpool_if.slave bus
);
   localparam int XW   = DW - 1;
   localparam int PH   = OH / 2;
   localparam int PW   = OW / 2;
   localparam int RCW  = (OH > 1) ? $clog2(OH) : 1;
   localparam int CCW  = (OW > 1) ? $clog2(OW) : 1;
   localparam int RW   = (PH > 1) ? $clog2(PH) : 1;
   localparam int CW   = (PW > 1) ? $clog2(PW) : 1;
   localparam int LBN  = (PW > 0) ? PW : 1;

   logic [RCW-1:0] r;
   logic [CCW-1:0] c;
   logic [XW-1:0]  h;
   logic [XW-1:0]  x;
   logic [XW-1:0]  m;
   logic [XW-1:0]  lb_q;
   logic [XW-1:0]  pool;
   logic [CW-1:0]  idx;
   logic           last_c;
   logic           last_r;
   logic           last_win;
   logic           pool_beat;
   logic           write_beat;

   logic [XW-1:0]  lb [0:LBN-1];

   always_comb begin
      x          = bus.in_data[DW-1] ? '0 : bus.in_data[DW-2:0];
      m          = (x > h) ? x : h;
      idx        = CW'(c >> 1);
      lb_q       = lb[idx];
      pool       = (m > lb_q) ? m : lb_q;
      last_c     = (c == CCW'(OW - 1));
      last_r     = (r == RCW'(OH - 1));
      // Last pooled window, which also covers odd dimensions with a dropped tail.
      last_win   = ((r >> 1) == RCW'(PH - 1)) && ((c >> 1) == CCW'(PW - 1));
      pool_beat  = bus.in_valid & c[0] & r[0];
      write_beat = bus.in_valid & c[0] & ~r[0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r <= '0;
         c <= '0;
         h <= '0;
      end else if (bus.in_valid) begin
         if (last_c) begin
            c <= '0;
            r <= last_r ? '0 : r + 1'b1;
         end else begin
            c <= c + 1'b1;
         end
         if (!c[0]) begin
            h <= x;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.out_data   <= '0;
         bus.out_row    <= '0;
         bus.out_col    <= '0;
      end else begin
         bus.out_valid  <= pool_beat;
         bus.frame_done <= pool_beat & last_win;
         if (pool_beat) begin
            bus.out_data <= pool;
            bus.out_row  <= RW'(r >> 1);
            bus.out_col  <= CW'(c >> 1);
         end
      end
   end

   // Every entry is rewritten on an even row before its odd-row read, so no reset.
   always_ff @(posedge clk) begin
      if (write_beat) begin
         lb[idx] <= m;
      end
   end
endmodule

// File: tb/tb_relu_maxpool.sv
// Randomised bench for relu_maxpool: window maxima are computed from a stored
// copy of the frame and checked on every cycle against the DUT outputs.
module tb_relu_maxpool;
  localparam int OH = 26;
  localparam int OW = 26;
  localparam int DW = 19;

  typedef struct packed {
    logic [31:0] cyc;
    logic        fd;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [17:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   check_en = 1'b0;

  exp_t        exp_q[$];
  logic [18:0] fr [0:OH-1][0:OW-1];
  int          pr = 0;
  int          pc = 0;
  logic [17:0] hold_data = '0;
  logic [3:0]  hold_row = '0;
  logic [3:0]  hold_col = '0;

  int          n_valid, n_done;
  logic [17:0] first_data, done_data, win35, max_seen;
  int          sp_r, sp_c;
  logic [18:0] sp_v;

  relu_maxpool_if #(.OH(OH), .OW(OW), .DW(DW)) bus ();

  relu_maxpool #(.OH(OH), .OW(OW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // model
  function automatic logic [17:0] relu(logic [18:0] v);
    return v[18] ? 18'd0 : v[17:0];
  endfunction

  function automatic logic [17:0] window_max(int i, int j);
    logic [17:0] best;
    best = '0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (relu(fr[2*i+dr][2*j+dc]) > best) best = relu(fr[2*i+dr][2*j+dc]);
    return best;
  endfunction

  function automatic logic [18:0] sample(int mode, int r, int c, int off);
    case (mode)
      0: return 19'(r * OW + c + off);
      1: return 19'h7FFFB;
      2: return (r == sp_r && c == sp_c) ? sp_v : 19'd0;
      default: return 19'($urandom());
    endcase
  endfunction

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // driver
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drive_beat(logic [18:0] v, int gap_pct);
    exp_t e;
    while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idle(1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    fr[pr][pc]   = v;
    if ((pr % 2) == 1 && (pc % 2) == 1) begin
      e.cyc  = 32'(cyc + 1);
      e.fd   = (pr == OH - 1 && pc == OW - 1);
      e.row  = 4'(pr / 2);
      e.col  = 4'(pc / 2);
      e.data = window_max(pr / 2, pc / 2);
      exp_q.push_back(e);
    end
    if (pc == OW - 1) begin
      pc = 0;
      pr = (pr == OH - 1) ? 0 : pr + 1;
    end else begin
      pc = pc + 1;
    end
  endtask

  task automatic run_frame(int mode, int off, int gap_pct);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        drive_beat(sample(mode, r, c, off), gap_pct);
  endtask

  task automatic clear_stats();
    n_valid = 0; n_done = 0;
    first_data = '1; done_data = '1; win35 = '1; max_seen = '0;
  endtask

  // scoreboard: every cycle, outputs must match the pending expectation or hold
  always @(negedge clk) begin
    if (rst && check_en) begin
      exp_t e;
      n_cmp++;
      if (exp_q.size() > 0 && int'(exp_q[0].cyc) == cyc) begin
        e = exp_q.pop_front();
        if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_row !== e.row ||
            bus.out_col !== e.col || bus.frame_done !== e.fd) begin
          n_fail++;
          $display("FAIL window(%0d,%0d) cyc %0d: got v=%b d=%0d r=%0d c=%0d fd=%b expected d=%0d fd=%b",
                   e.row, e.col, cyc, bus.out_valid, bus.out_data, bus.out_row, bus.out_col,
                   bus.frame_done, e.data, e.fd);
        end
        hold_data = e.data; hold_row = e.row; hold_col = e.col;
      end else if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.out_data !== hold_data ||
                   bus.out_row !== hold_row || bus.out_col !== hold_col) begin
        n_fail++;
        $display("FAIL idle cyc %0d: got v=%b fd=%b d=%0d r=%0d c=%0d expected v=0 fd=0 d=%0d r=%0d c=%0d",
                 cyc, bus.out_valid, bus.frame_done, bus.out_data, bus.out_row, bus.out_col,
                 hold_data, hold_row, hold_col);
      end
      if (bus.out_valid) begin
        n_valid++;
        if (bus.out_row == 0 && bus.out_col == 0) first_data = bus.out_data;
        if (bus.out_row == 3 && bus.out_col == 5) win35 = bus.out_data;
        if (bus.out_data > max_seen) max_seen = bus.out_data;
      end
      if (bus.frame_done) begin
        n_done++;
        done_data = bus.out_data;
      end
    end
  end

  // stimulus
  initial begin
    logic [18:0] vals [0:1];
    vals[0] = 19'd1000;
    vals[1] = 19'd262143;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_row", bus.out_row, 0);
    check("reset_out_col", bus.out_col, 0);
    check("reset_frame_done", bus.frame_done, 0);
    #2 rst = 1'b1;
    check_en = 1'b1;

    clear_stats();
    run_frame(0, 0, 0);
    idle(3);
    check("ramp_count", n_valid, 169);
    check("ramp_done_count", n_done, 1);
    check("ramp_first", first_data, 27);
    check("ramp_last", done_data, 675);
    check("model_pin_5_7", window_max(5, 7), 11 * 26 + 15);

    clear_stats();
    run_frame(1, 0, 0);
    idle(3);
    check("neg_count", n_valid, 169);
    check("neg_max", max_seen, 0);

    for (int vi = 0; vi < 2; vi++) begin
      for (int k = 0; k < 4; k++) begin
        sp_r = 6 + k / 2;
        sp_c = 10 + k % 2;
        sp_v = vals[vi];
        clear_stats();
        run_frame(2, 0, 0);
        idle(2);
        check("sparse_count", n_valid, 169);
        check("sparse_win35", win35, vals[vi]);
        check("sparse_max", max_seen, vals[vi]);
      end
    end

    clear_stats();
    run_frame(0, 0, 50);
    idle(3);
    check("gap_count", n_valid, 169);
    check("gap_first", first_data, 27);
    check("gap_last", done_data, 675);

    clear_stats();
    run_frame(0, 0, 0);
    run_frame(0, 1000, 0);
    idle(3);
    check("b2b_count", n_valid, 338);
    check("b2b_done_count", n_done, 2);
    check("b2b_last", done_data, 1675);

    clear_stats();
    run_frame(3, 0, 30);
    idle(3);
    check("rand_count", n_valid, 169);

    // reset mid-frame right after beat (9,4)
    while (!(pr == 9 && pc == 5)) drive_beat(sample(0, pr, pc, 0), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_row", bus.out_row, 0);
    check("midrst_out_col", bus.out_col, 0);
    check("midrst_frame_done", bus.frame_done, 0);
    exp_q.delete();
    hold_data = '0; hold_row = '0; hold_col = '0;
    pr = 0; pc = 0;
    @(posedge clk); #3 rst = 1'b1;
    clear_stats();
    run_frame(0, 0, 0);
    idle(3);
    check("postrst_count", n_valid, 169);
    check("postrst_first", first_data, 27);
    check("postrst_last", done_data, 675);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
